// File: rtl/fpu_issue_sched.sv
// Issue scheduler for FPU lanes u1/u3/u5: per-lane writeback-slot reservation for pipelined ops
// plus round-robin arbitration of one shared non-pipelined divide/sqrt unit.
module fpu_issue_sched #(
    parameter int unsigned LAT_MAX = 8,
    parameter int unsigned DIV_LAT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_en,
    input  logic [2:0] req_div,
    input  logic [8:0] req_lat,
    input  logic       flush,
    output logic [2:0] grant,
    output logic [2:0] lat_err,
    output logic       div_busy,
    output logic [1:0] div_owner,
    output logic [2:0] div_done,
    output logic [2:0] wb_now
);

    localparam int unsigned CntW = $clog2(DIV_LAT + 1);

    logic [LAT_MAX-1:0] resv_q [3];
    logic [LAT_MAX-1:0] resv_d [3];
    logic               div_busy_q, div_busy_d;
    logic [CntW-1:0]    div_cnt_q, div_cnt_d;
    logic [1:0]         div_owner_q, div_owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;

    logic [2:0] pipe_gnt;
    logic [2:0] lat_zero;
    logic [2:0] div_gnt;
    logic [2:0] done;
    logic [2:0] div_cand;
    logic [1:0] ord [3];
    logic [1:0] div_pick;
    logic       div_pick_vld;

    // Pipelined grants: the target slot must be free in the lane's reservation window and must
    // not collide with the divider writeback already booked for the owner lane.
    always_comb begin
        logic [2:0]         lat_i;
        logic [LAT_MAX-1:0] slot;
        logic               lat_ok;
        logic               blk;
        lat_i    = '0;
        slot     = '0;
        lat_ok   = 1'b0;
        blk      = 1'b0;
        pipe_gnt = '0;
        lat_zero = '0;
        for (int i = 0; i < 3; i++) begin
            lat_i  = req_lat[3*i +: 3];
            slot   = LAT_MAX'(1) << lat_i;
            lat_ok = (lat_i != 3'd0) && (32'(lat_i) < LAT_MAX);
            blk    = div_busy_q && (div_owner_q == 2'(i)) && (div_cnt_q == CntW'(lat_i));
            if (req_en[i] && !req_div[i]) begin
                if (lat_i == 3'd0) begin
                    lat_zero[i] = 1'b1;
                end else if (lat_ok && !(|(resv_q[i] & slot)) && !blk) begin
                    pipe_gnt[i] = 1'b1;
                end
            end
            resv_d[i] = (resv_q[i] >> 1)
                      | (pipe_gnt[i] ? (LAT_MAX'(1) << (lat_i - 3'd1)) : '0);
        end
    end

    // Round-robin search order starting at rr_ptr.
    always_comb begin
        ord[0] = 2'd0;
        ord[1] = 2'd1;
        ord[2] = 2'd2;
        unique case (rr_ptr_q)
            2'd1: begin
                ord[0] = 2'd1;
                ord[1] = 2'd2;
                ord[2] = 2'd0;
            end
            2'd2: begin
                ord[0] = 2'd2;
                ord[1] = 2'd0;
                ord[2] = 2'd1;
            end
            default: begin
                ord[0] = 2'd0;
                ord[1] = 2'd1;
                ord[2] = 2'd2;
            end
        endcase
    end

    always_comb begin
        div_cand     = req_en & req_div;
        div_pick     = 2'd0;
        div_pick_vld = 1'b0;
        // Walk lowest priority first so the highest-priority candidate wins last.
        for (int k = 2; k >= 0; k--) begin
            if (div_cand[ord[k]]) begin
                div_pick     = ord[k];
                div_pick_vld = 1'b1;
            end
        end
        div_gnt = '0;
        if (!div_busy_q && !flush && div_pick_vld) begin
            div_gnt[div_pick] = 1'b1;
        end
        done = '0;
        if (div_busy_q && (div_cnt_q == '0) && !flush) begin
            done[div_owner_q] = 1'b1;
        end
    end

    always_comb begin
        div_busy_d  = div_busy_q;
        div_cnt_d   = div_cnt_q;
        div_owner_d = div_owner_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            div_busy_d  = 1'b0;
            div_cnt_d   = '0;
            div_owner_d = 2'd0;
        end else if (div_busy_q) begin
            if (div_cnt_q == '0) begin
                div_busy_d  = 1'b0;
                div_owner_d = 2'd0;
            end else begin
                div_cnt_d = div_cnt_q - CntW'(1);
            end
        end else if (div_gnt != 3'b000) begin
            div_busy_d  = 1'b1;
            div_owner_d = div_pick;
            div_cnt_d   = CntW'(DIV_LAT);
            rr_ptr_d    = (div_pick == 2'd2) ? 2'd0 : div_pick + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                resv_q[i] <= '0;
            end
            div_busy_q  <= 1'b0;
            div_cnt_q   <= '0;
            div_owner_q <= 2'd0;
            rr_ptr_q    <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                resv_q[i] <= resv_d[i];
            end
            div_busy_q  <= div_busy_d;
            div_cnt_q   <= div_cnt_d;
            div_owner_q <= div_owner_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Grants are combinational from the request, so they are forced low while reset is held.
    assign grant     = (pipe_gnt | div_gnt) & {3{rst}};
    assign lat_err   = lat_zero & {3{rst}};
    assign div_busy  = div_busy_q;
    assign div_owner = div_owner_q;
    assign div_done  = done;
    assign wb_now    = {resv_q[2][0], resv_q[1][0], resv_q[0][0]} | done;

endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
Issue scheduler for the three FPU issue lanes (u1, u3, u5). Each lane writes back on its own result buses (FUFH/FUFL per lane). The block grants each lane's pipelined FP ops only when that lane's writeback slot at the op's latency is free. It also arbitrates one shared, non-pipelined divide/sqrt unit among the three lanes.

Parameters:
LAT_MAX, 8, reservation window depth; legal pipelined latency is 1..LAT_MAX-1.
DIV_LAT, 20, divide/sqrt latency in cycles from grant to writeback; must be greater than LAT_MAX.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req_en  in  3  per-lane request valid; bit0=u1, bit1=u3, bit2=u5
req_div  in  3  per-lane request targets the shared divider (meaningful only with req_en)
req_lat  in  9  per-lane pipelined latency, 3 bits per lane, lane i at [3i+2:3i]
flush  in  1  aborts the divider op in flight
grant  out  3  per-lane grant, combinational, same cycle as request
lat_err  out  3  per-lane illegal latency pulse (req_en & ~req_div & lat==0)
div_busy  out  1  divider occupied
div_owner  out  2  lane index owning the divider; 0 when idle
div_done  out  3  one-hot divider writeback pulse
wb_now  out  3  per-lane writeback occurs this cycle (pipelined or divider)

Behaviour:
- State per lane: resv_i[LAT_MAX-1:0]. resv_i[k]=1 means lane i writeback in cycle t+k is occupied.
- Divider state: div_busy, div_cnt (countdown), div_owner, rr_ptr[1:0] (values 0..2).
- Reset (rst low, async): resv=0, div_busy=0, div_cnt=0, div_owner=0, rr_ptr=0.
- Effect of reset on outputs: grant, div_done, wb_now, lat_err go to 0. div_busy=0 and div_owner=0.
- Reset mid-divide drops the op silently; no div_done is issued.
- Blocking term: blk_i[k] = div_busy & div_owner==i & div_cnt==k. This reserves the divider writeback slot against pipelined ops of the owner lane.
- Pipelined grant: grant_i = req_en_i & ~req_div_i & lat!=0 & ~resv_i[lat] & ~blk_i[lat].
  - lat==0 gives grant 0 and lat_err_i=1 for that cycle.
- Lanes are independent; up to 3 pipelined grants per cycle.
- Reservation update each edge: resv_i <= (resv_i>>1) | (grant_i ? 1<<(lat-1) : 0).
  - Bit LAT_MAX-1 fills with 0.
- Divider grant is issued only when div_busy=0. Candidates: lanes with req_en & req_div.
  - Round-robin pick starts at rr_ptr, order rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
  - Exactly one lane is granted.
  - Next edge: div_busy=1, div_owner=lane, div_cnt=DIV_LAT, rr_ptr=(lane+1) mod 3.
- Divider request while div_busy=1 gives grant 0; the requester retries.
- A divider request is never granted in the cycle div_done fires. The divider re-arbitrates the cycle after.
- div_cnt decrements each cycle while busy.
  - When div_cnt==1 in cycle t, the writeback happens in cycle t+1.
  - Exactly: div_done[owner]=1 in the cycle div_cnt==0 & div_busy. div_busy clears at the end of that cycle.
- wb_now_i = resv_i[0] | div_done_i. Pipelined grants must never make resv_i[0] and div_done_i coincide; this is guaranteed by blk.
- flush=1: div_busy, div_cnt and div_owner clear at the next edge; no div_done. Pipelined reservations are untouched.
  - A divider request in the same cycle as flush is not granted.
  - Pipelined requests in that cycle arbitrate normally.
- Same-cycle pipelined grant and divider grant on different lanes: both granted.
- One lane cannot request both kinds in one cycle, since req_div selects the kind.
- Wrap-around: rr_ptr moves 2→0.
- Two pipelined requests on one lane in consecutive cycles with latencies L and L-1 target the same slot. The second is refused.

Test Plan:
- Reset, then lane0 req lat=3 at cycle 0 → grant=001. Cycle 1 lane0 lat=2 → grant=000, because slot t+3 is taken. wb_now[0]=1 in cycle 3 only.
- lat=0 request on lane1 → grant[1]=0, lat_err=010 for one cycle, resv unchanged.
- All three lanes req_div at cycle 0, rr_ptr=0 → grant=001. div_busy=1 for cycles 1..21. div_done=001 in cycle 21. Re-request all three: lane1 is granted in cycle 22, then lane2, then lane0 (rr wrap).
- Lane0 owns the divider (granted cycle 0). At cycle 19 (div_cnt=2) lane0 pipelined lat=2 → refused. lat=1 → granted. Lane1 lat=2 at the same cycle → granted.
- flush at cycle 5 of a divide → div_busy=0 from cycle 6, no div_done ever. A pipelined reservation made at cycle 4 with lat=5 still yields wb_now in cycle 9.
- Assert rst low at cycle 10 of a divide with 3 pipelined reservations outstanding → all outputs 0 immediately. After release, no wb_now or div_done pulses appear.
